// File: rtl/uart_stream_bridge.sv
// Valid/ready stream front end for uart_controller: a Tx FIFO feeding a small
// start/wait-done handshake FSM, and an Rx FIFO that captures every rx_done pulse with its error tags.
module uart_stream_bridge #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int TX_FIFO_DEPTH   = 8,
  parameter int RX_FIFO_DEPTH   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [MAX_UART_DATA_W-1:0]       s_tx_data_i,
  input  logic                             s_tx_valid_i,
  output logic                             s_tx_ready_o,
  output logic [MAX_UART_DATA_W-1:0]       m_rx_data_o,
  output logic                             m_rx_perr_o,
  output logic                             m_rx_serr_o,
  output logic                             m_rx_valid_o,
  input  logic                             m_rx_ready_i,
  output logic                             ctl_tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]       ctl_tx_data_o,
  input  logic                             ctl_tx_busy_i,
  input  logic                             ctl_tx_done_i,
  input  logic                             ctl_rx_done_i,
  input  logic [MAX_UART_DATA_W-1:0]       ctl_rx_data_i,
  input  logic                             ctl_rx_parity_err_i,
  input  logic                             ctl_rx_stop_err_i,
  input  logic                             clr_overflow_i,
  output logic                             rx_overflow_o,
  output logic [$clog2(TX_FIFO_DEPTH):0]   tx_level_o,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level_o
);

  localparam int W     = MAX_UART_DATA_W;
  localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
  localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
  localparam int RX_EW = W + 2;
  localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_FIFO_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW+1)'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_DONE
  } tx_state_e;

  // Tx FIFO
  logic [W-1:0]     tx_mem_q [TX_FIFO_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d;
  logic [TX_AW-1:0] tx_rptr_q, tx_rptr_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic             tx_full, tx_empty, tx_push, tx_pop;

  tx_state_e        tx_state_q, tx_state_d;
  logic [W-1:0]     ctl_tx_data_q, ctl_tx_data_d;

  // Rx FIFO
  logic [RX_EW-1:0] rx_mem_q [RX_FIFO_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d;
  logic [RX_AW-1:0] rx_rptr_q, rx_rptr_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic             rx_full, rx_empty, rx_push, rx_pop, ovf_set;
  logic             rx_ovf_q, rx_ovf_d;
  logic [RX_EW-1:0] rx_head;

  assign tx_full  = (tx_cnt_q == TX_FULL_LVL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = s_tx_valid_i & ~tx_full;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
    if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= s_tx_data_i;
  end

  // The head byte is popped into the output register on the IDLE->START edge,
  // so ctl_tx_data_o is already stable when the start pulse is seen.
  always_comb begin
    tx_state_d    = tx_state_q;
    ctl_tx_data_d = ctl_tx_data_q;
    tx_pop        = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !ctl_tx_busy_i) begin
          tx_pop        = 1'b1;
          ctl_tx_data_d = tx_mem_q[tx_rptr_q];
          tx_state_d    = TX_START;
        end
      end
      TX_START:     tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (ctl_tx_done_i) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  assign rx_full  = (rx_cnt_q == RX_FULL_LVL);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = ~rx_empty & m_rx_ready_i;
  // When full, a simultaneous pop frees the slot the write pointer sits on.
  assign rx_push  = ctl_rx_done_i & (~rx_full | rx_pop);
  assign ovf_set  = ctl_rx_done_i & rx_full & ~rx_pop;

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (ovf_set)             rx_ovf_d = 1'b1;
    else if (clr_overflow_i) rx_ovf_d = 1'b0;
    else                     rx_ovf_d = rx_ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= {ctl_rx_stop_err_i, ctl_rx_parity_err_i, ctl_rx_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      tx_state_q    <= TX_IDLE;
      ctl_tx_data_q <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_cnt_q      <= '0;
      rx_ovf_q      <= 1'b0;
    end else begin
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_state_q    <= tx_state_d;
      ctl_tx_data_q <= ctl_tx_data_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_ovf_q      <= rx_ovf_d;
    end
  end

  // Head is gated so the un-reset memory never shows through while empty.
  assign rx_head        = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
  assign m_rx_data_o    = rx_head[W-1:0];
  assign m_rx_perr_o    = rx_head[W];
  assign m_rx_serr_o    = rx_head[W+1];
  assign m_rx_valid_o   = ~rx_empty;
  assign s_tx_ready_o   = ~tx_full;
  assign ctl_tx_start_o = (tx_state_q == TX_START);
  assign ctl_tx_data_o  = ctl_tx_data_q;
  assign rx_overflow_o  = rx_ovf_q;
  assign tx_level_o     = tx_cnt_q;
  assign rx_level_o     = rx_cnt_q;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Bench for uart_stream_bridge: a queue-based reference model plus an emulated
// controller (busy/done, optional loopback), directed scenarios then random traffic.
module tb_uart_stream_bridge;
  localparam int W   = 8;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] s_tx_data_i;
  logic         s_tx_valid_i;
  logic         s_tx_ready_o;
  logic [W-1:0] m_rx_data_o;
  logic         m_rx_perr_o, m_rx_serr_o, m_rx_valid_o;
  logic         m_rx_ready_i;
  logic         ctl_tx_start_o;
  logic [W-1:0] ctl_tx_data_o;
  logic         ctl_tx_busy_i, ctl_tx_done_i, ctl_rx_done_i;
  logic [W-1:0] ctl_rx_data_i;
  logic         ctl_rx_parity_err_i, ctl_rx_stop_err_i;
  logic         clr_overflow_i, rx_overflow_o;
  logic [3:0]   tx_level_o, rx_level_o;

  always #5 clk_i = ~clk_i;

  uart_stream_bridge #(.MAX_UART_DATA_W(W), .TX_FIFO_DEPTH(TXD), .RX_FIFO_DEPTH(RXD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_tx_data_i(s_tx_data_i), .s_tx_valid_i(s_tx_valid_i), .s_tx_ready_o(s_tx_ready_o),
    .m_rx_data_o(m_rx_data_o), .m_rx_perr_o(m_rx_perr_o), .m_rx_serr_o(m_rx_serr_o),
    .m_rx_valid_o(m_rx_valid_o), .m_rx_ready_i(m_rx_ready_i),
    .ctl_tx_start_o(ctl_tx_start_o), .ctl_tx_data_o(ctl_tx_data_o),
    .ctl_tx_busy_i(ctl_tx_busy_i), .ctl_tx_done_i(ctl_tx_done_i),
    .ctl_rx_done_i(ctl_rx_done_i), .ctl_rx_data_i(ctl_rx_data_i),
    .ctl_rx_parity_err_i(ctl_rx_parity_err_i), .ctl_rx_stop_err_i(ctl_rx_stop_err_i),
    .clr_overflow_i(clr_overflow_i), .rx_overflow_o(rx_overflow_o),
    .tx_level_o(tx_level_o), .rx_level_o(rx_level_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] exp_sent[$];
  logic [9:0] rxq[$];
  int         phase;          // 0 idle, 1 start pulse, 2 waiting for done
  logic [7:0] last_data;
  logic       ovf;
  int         n_starts, n_dones;
  bit         last_tpush;

  // Stimulus drives
  logic       drv_tx_valid, drv_rx_done, drv_perr, drv_serr, drv_rx_ready, drv_clr;
  logic [7:0] drv_tx_data, drv_rx_data;
  logic       force_busy, loopback, rand_busy_en;

  // Emulated controller
  int         emu_rem;
  logic       emu_busy, emu_done, emu_lb;
  logic [7:0] emu_byte;
  logic       obs_start;
  logic [7:0] obs_tdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete(); exp_sent.delete(); rxq.delete();
    phase = 0; last_data = 8'h00; ovf = 1'b0;
    emu_rem = 0; emu_busy = 1'b0; emu_done = 1'b0; emu_lb = 1'b0; emu_byte = 8'h00;
    obs_start = 1'b0; obs_tdata = 8'h00;
  endtask

  task automatic check_outputs();
    obs_start = ctl_tx_start_o;
    obs_tdata = ctl_tx_data_o;
    chk("tx_ready", s_tx_ready_o, txq.size() < TXD);
    chk("tx_level", tx_level_o, txq.size());
    chk("tx_start", ctl_tx_start_o, phase == 1);
    chk("tx_data",  ctl_tx_data_o, last_data);
    chk("rx_valid", m_rx_valid_o, rxq.size() != 0);
    chk("rx_level", rx_level_o, rxq.size());
    chk("rx_ovf",   rx_overflow_o, ovf);
    if (rxq.size() != 0) begin
      chk("rx_data", m_rx_data_o, rxq[0][7:0]);
      chk("rx_perr", m_rx_perr_o, rxq[0][8]);
      chk("rx_serr", m_rx_serr_o, rxq[0][9]);
    end
  endtask

  task automatic model_step();
    bit tpush, tpop, rpop, racc, rset;
    logic [7:0] e;
    tpush = s_tx_valid_i && (txq.size() < TXD);
    tpop  = (phase == 0) && (txq.size() != 0) && !ctl_tx_busy_i;
    if (obs_start) begin
      n_starts++;
      if (exp_sent.size() == 0) chk("tx_extra_start", obs_start, 1'b0);
      else begin
        e = exp_sent.pop_front();
        chk("tx_order", obs_tdata, e);
      end
    end
    case (phase)
      0:       if (tpop) phase = 1;
      1:       phase = 2;
      default: if (ctl_tx_done_i) phase = 0;
    endcase
    if (tpop) last_data = txq.pop_front();
    if (tpush) begin
      txq.push_back(s_tx_data_i);
      exp_sent.push_back(s_tx_data_i);
    end
    last_tpush = tpush;

    rpop = (rxq.size() != 0) && m_rx_ready_i;
    racc = 1'b0; rset = 1'b0;
    if (ctl_rx_done_i) begin
      if (rxq.size() < RXD || rpop) racc = 1'b1;
      else rset = 1'b1;
    end
    if (rpop) void'(rxq.pop_front());
    if (racc) rxq.push_back({ctl_rx_stop_err_i, ctl_rx_parity_err_i, ctl_rx_data_i});
    if (rset) ovf = 1'b1;
    else if (clr_overflow_i) ovf = 1'b0;
  endtask

  task automatic emu_step();
    emu_done = 1'b0; emu_lb = 1'b0;
    if (obs_start) begin
      emu_rem  = $urandom_range(1, 4);
      emu_busy = 1'b1;
      emu_byte = obs_tdata;
    end else if (emu_rem > 0) begin
      emu_rem--;
      if (emu_rem == 0) begin
        emu_busy = 1'b0; emu_done = 1'b1; emu_lb = loopback; n_dones++;
      end
    end else begin
      emu_busy = rand_busy_en && ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic tick();
    s_tx_valid_i        = drv_tx_valid;
    s_tx_data_i         = drv_tx_data;
    ctl_rx_done_i       = drv_rx_done | emu_lb;
    ctl_rx_data_i       = emu_lb ? emu_byte : drv_rx_data;
    ctl_rx_parity_err_i = emu_lb ? 1'b0 : drv_perr;
    ctl_rx_stop_err_i   = emu_lb ? 1'b0 : drv_serr;
    m_rx_ready_i        = drv_rx_ready;
    clr_overflow_i      = drv_clr;
    ctl_tx_busy_i       = emu_busy | force_busy;
    ctl_tx_done_i       = emu_done;
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_step();
    emu_step();
    #1;
  endtask

  task automatic drv_idle();
    drv_tx_valid = 0; drv_tx_data = 0; drv_rx_done = 0; drv_rx_data = 0;
    drv_perr = 0; drv_serr = 0; drv_rx_ready = 0; drv_clr = 0;
  endtask

  task automatic rx_inject(input logic [7:0] d, input logic p, input logic s, input logic rdy);
    drv_rx_done = 1; drv_rx_data = d; drv_perr = p; drv_serr = s; drv_rx_ready = rdy;
    tick();
    drv_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  k, s0;
    bit  ok;
    rst_i = 1'b1;
    force_busy = 0; loopback = 0; rand_busy_en = 0;
    n_starts = 0; n_dones = 0; last_tpush = 0;
    drv_idle();
    model_reset();
    s_tx_valid_i = 0; s_tx_data_i = 0; ctl_rx_done_i = 0; ctl_rx_data_i = 0;
    ctl_rx_parity_err_i = 0; ctl_rx_stop_err_i = 0; m_rx_ready_i = 0;
    clr_overflow_i = 0; ctl_tx_busy_i = 0; ctl_tx_done_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset asserted mid-cycle right after a push
    drv_tx_valid = 1; drv_tx_data = 8'hA5;
    tick();
    drv_idle();
    chk("pre_rst_level", tx_level_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_tx_ready", s_tx_ready_o, 1);
    chk("rst_tx_level", tx_level_o, 0);
    chk("rst_rx_level", rx_level_o, 0);
    chk("rst_start",    ctl_tx_start_o, 0);
    chk("rst_tx_data",  ctl_tx_data_o, 0);
    chk("rst_rx_valid", m_rx_valid_o, 0);
    chk("rst_rx_data",  {m_rx_serr_o, m_rx_perr_o, m_rx_data_o}, 0);
    chk("rst_ovf",      rx_overflow_o, 0);
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (4) tick();

    // Single Tx with loopback, latency N+2
    loopback = 1;
    drv_tx_valid = 1; drv_tx_data = 8'h3C;
    tick();
    drv_idle();
    chk("single_accept", last_tpush, 1);
    tick();
    chk("lat_n1_start", obs_start, 0);
    tick();
    chk("lat_n2_start", obs_start, 1);
    chk("lat_n2_data",  obs_tdata, 8'h3C);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = m_rx_valid_o; end
    chk("loop_rx_seen", ok, 1);
    chk("loop_rx_data", m_rx_data_o, 8'h3C);
    drv_rx_ready = 1; tick(); drv_idle();
    loopback = 0;
    repeat (2) tick();

    // Tx burst of 9 with the controller held busy
    s0 = n_starts;
    force_busy = 1;
    for (int i = 0; i < 8; i++) begin
      drv_tx_valid = 1; drv_tx_data = 8'(i);
      tick();
    end
    drv_tx_data = 8'h08;
    tick();
    chk("burst_ready_low", s_tx_ready_o, 0);
    chk("burst_level8",    tx_level_o, 8);
    chk("burst_9th_held",  last_tpush, 0);
    force_busy = 0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin tick(); ok = last_tpush; end
    chk("burst_9th_accept", ok, 1);
    drv_idle();
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      ok = (exp_sent.size() == 0) && (txq.size() == 0) && (phase == 0);
    end
    chk("burst_drained", ok, 1);
    chk("burst_starts",  n_starts - s0, 9);
    chk("start_per_done", n_starts, n_dones);

    // Rx tags
    rx_inject(8'h55, 1, 0, 0);
    rx_inject(8'h66, 0, 1, 0);
    tick();
    chk("tag_level", rx_level_o, 2);
    chk("tag0_data", m_rx_data_o, 8'h55);
    chk("tag0_perr", m_rx_perr_o, 1);
    chk("tag0_serr", m_rx_serr_o, 0);
    drv_rx_ready = 1; tick(); drv_idle();
    chk("tag1_data", m_rx_data_o, 8'h66);
    chk("tag1_perr", m_rx_perr_o, 0);
    chk("tag1_serr", m_rx_serr_o, 1);
    drv_rx_ready = 1; tick(); drv_idle();

    // Rx overflow: 9 writes into a depth-8 FIFO
    for (int i = 0; i < 9; i++) rx_inject(8'(8'h80 + i), 0, 0, 0);
    chk("ovf_level", rx_level_o, 8);
    chk("ovf_flag",  rx_overflow_o, 1);
    chk("ovf_head",  m_rx_data_o, 8'h80);
    drv_clr = 1; tick(); drv_idle();
    chk("ovf_cleared", rx_overflow_o, 0);

    // Full + simultaneous pop: write accepted at the tail
    rx_inject(8'h77, 0, 0, 1);
    chk("fullpop_level", rx_level_o, 8);
    chk("fullpop_ovf",   rx_overflow_o, 0);
    drv_rx_ready = 1;
    repeat (7) tick();
    chk("fullpop_tail", m_rx_data_o, 8'h77);
    tick();
    drv_idle();
    tick();
    chk("fullpop_empty", m_rx_valid_o, 0);

    // Random traffic
    rand_busy_en = 1;
    for (int i = 0; i < 3000; i++) begin
      drv_tx_valid = ($urandom_range(0, 1) == 1);
      drv_tx_data  = 8'($urandom);
      drv_rx_done  = ($urandom_range(0, 9) < 3);
      drv_rx_data  = 8'($urandom);
      drv_perr     = ($urandom_range(0, 3) == 0);
      drv_serr     = ($urandom_range(0, 3) == 0);
      drv_rx_ready = ($urandom_range(0, 9) < 5);
      drv_clr      = ($urandom_range(0, 19) == 0);
      tick();
    end
    drv_idle();
    rand_busy_en = 0;
    drv_rx_ready = 1;
    ok = 0;
    for (k = 0; k < 500 && !ok; k++) begin
      tick();
      ok = (exp_sent.size() == 0) && (txq.size() == 0) && (phase == 0) && (rxq.size() == 0);
    end
    chk("rand_drained", ok, 1);
    chk("rand_start_per_done", n_starts, n_dones);
    drv_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
